// File: rtl/tedv3_imem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port instruction RAM.
// Grants are combinational from registered owner state; read data returns one cycle after issue.
module tedv3_imem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] p0_address,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [BE_W-1:0]   p0_byteenable,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic              p0_waitrequest,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_readdatavalid,

  input  logic [ADDR_W-1:0] p1_address,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [BE_W-1:0]   p1_byteenable,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic              p1_waitrequest,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

  owner_t           owner;
  logic             rr_last;
  logic [CNT_W-1:0] burst_cnt;
  logic             rd_pend;
  logic             rd_port;

  logic             req0, req1;
  logic             grant0, grant1;
  logic             issue;
  logic             burst_open;
  logic [CNT_W-1:0] burst_inc;

  assign req0       = p0_read | p0_write;
  assign req1       = p1_read | p1_write;
  assign burst_open = burst_cnt < BURST_MAX;
  assign burst_inc  = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);

  // Nothing is granted while reset is high, which also forces both waitrequests high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      case (owner)
        IDLE: begin
          if (req0 && req1) begin
            grant0 = rr_last;
            grant1 = !rr_last;
          end else begin
            grant0 = req0;
            grant1 = req1;
          end
        end
        OWN0: begin
          if (req0 && (!req1 || burst_open)) grant0 = 1'b1;
          else                               grant1 = req1;
        end
        OWN1: begin
          if (req1 && (!req0 || burst_open)) grant1 = 1'b1;
          else                               grant0 = req0;
        end
        default: ;
      endcase
    end
  end

  assign issue = grant0 | grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_port   <= 1'b0;
    end else begin
      rd_pend <= issue && !mem_write;
      rd_port <= grant1;
      if (grant0) begin
        owner     <= OWN0;
        rr_last   <= 1'b0;
        burst_cnt <= (owner == OWN0) ? burst_inc : CNT_W'(1);
      end else if (grant1) begin
        owner     <= OWN1;
        rr_last   <= 1'b1;
        burst_cnt <= (owner == OWN1) ? burst_inc : CNT_W'(1);
      end else begin
        owner     <= IDLE;
        burst_cnt <= '0;
      end
    end
  end

  assign p0_waitrequest = !grant0;
  assign p1_waitrequest = !grant1;

  // Port 0 drives the RAM bus by default; its values are don't-care when not issuing.
  assign mem_address    = grant1 ? p1_address    : p0_address;
  assign mem_byteenable = grant1 ? p1_byteenable : p0_byteenable;
  assign mem_writedata  = grant1 ? p1_writedata  : p0_writedata;
  assign mem_write      = grant1 ? p1_write      : (grant0 & p0_write);
  assign mem_chipselect = issue;
  assign mem_clken      = 1'b1;

  assign p0_readdata      = mem_readdata;
  assign p1_readdata      = mem_readdata;
  assign p0_readdatavalid = rd_pend && !rd_port && !reset;
  assign p1_readdatavalid = rd_pend &&  rd_port && !reset;

endmodule

// File: tb/tb_tedv3_imem_arbiter.sv
// Directed bench for tedv3_imem_arbiter with a behavioural RAM (registered q) behind mem_*.
// RAM word at address a is preloaded with 32'h1000_0000 | a.
module tb_tedv3_imem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] p0_address, p1_address;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic [31:0] p0_writedata, p1_writedata;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  int tests = 0;
  int fails = 0;
  int p1_stalls;

  logic [31:0] ram [0:65535];

  always #5 clk = ~clk;

  tedv3_imem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .p0_address(p0_address), .p0_read(p0_read), .p0_write(p0_write),
    .p0_byteenable(p0_byteenable), .p0_writedata(p0_writedata),
    .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
    .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
    .p1_byteenable(p1_byteenable), .p1_writedata(p1_writedata),
    .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
    .p1_readdatavalid(p1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 32'h1000_0000 | 32'(i);
    mem_readdata = '0;
    reset = 1'b1;
    p0_address = '0; p0_read = 0; p0_write = 0; p0_byteenable = 4'hF; p0_writedata = '0;
    p1_address = '0; p1_read = 0; p1_write = 0; p1_byteenable = 4'hF; p1_writedata = '0;

    // Reset state, with a request present
    repeat (2) @(negedge clk);
    p0_read = 1; p1_read = 1;
    #1;
    chk1("rst_p0_wait", p0_waitrequest, 1'b1);
    chk1("rst_p1_wait", p1_waitrequest, 1'b1);
    chk1("rst_cs", mem_chipselect, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_p0_rdv", p0_readdatavalid, 1'b0);
    chk1("rst_p1_rdv", p1_readdatavalid, 1'b0);
    chk1("rst_clken", mem_clken, 1'b1);
    p0_read = 0; p1_read = 0;
    @(negedge clk); reset = 0;

    // 1: single p0 read of 0x0010
    @(negedge clk);
    p0_read = 1; p0_address = 16'h0010;
    #1;
    chk1("t1_p0_wait", p0_waitrequest, 1'b0);
    chk1("t1_cs", mem_chipselect, 1'b1);
    chk32("t1_addr", {16'h0, mem_address}, 32'h0000_0010);
    chk1("t1_mem_write", mem_write, 1'b0);
    @(negedge clk);
    p0_read = 0;
    #1;
    chk1("t1_p0_rdv", p0_readdatavalid, 1'b1);
    chk32("t1_p0_data", p0_readdata, 32'h1000_0010);
    chk1("t1_p1_rdv", p1_readdatavalid, 1'b0);
    @(negedge clk); #1;
    chk1("t1_p0_rdv_once", p0_readdatavalid, 1'b0);
    chk1("t1_p1_rdv_none", p1_readdatavalid, 1'b0);

    // 2: both request right after reset; p0 gets 8, then p1
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    @(negedge clk);
    p0_read = 1; p0_address = 16'h0020;
    p1_read = 1; p1_address = 16'h0030;
    p1_stalls = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk1($sformatf("t2_p0_wait_%0d", i), p0_waitrequest, 1'b0);
      chk1($sformatf("t2_p1_wait_%0d", i), p1_waitrequest, 1'b1);
      if (p1_waitrequest) p1_stalls++;
      @(negedge clk);
    end
    #1;
    chk1("t2_p0_wait_sw", p0_waitrequest, 1'b1);
    chk1("t2_p1_wait_sw", p1_waitrequest, 1'b0);
    chk1("t2_p0_rdv_last", p0_readdatavalid, 1'b1);
    chk32("t2_p0_data", p0_readdata, 32'h1000_0020);
    chk32("t2_p1_stalls", 32'(p1_stalls), 32'd8);
    @(negedge clk);
    p0_read = 0; p1_read = 0;
    #1;
    chk1("t2_p1_rdv", p1_readdatavalid, 1'b1);
    chk32("t2_p1_data", p1_readdata, 32'h1000_0030);
    chk1("t2_p0_rdv_off", p0_readdatavalid, 1'b0);

    // 3: p1 partial write then p0 readback
    @(negedge clk);
    p1_write = 1; p1_address = 16'h0100; p1_writedata = 32'hDEAD_BEEF; p1_byteenable = 4'b0011;
    #1;
    chk1("t3_p1_wait", p1_waitrequest, 1'b0);
    chk1("t3_mem_write", mem_write, 1'b1);
    chk32("t3_mem_be", {28'h0, mem_byteenable}, 32'h0000_0003);
    chk32("t3_mem_wdata", mem_writedata, 32'hDEAD_BEEF);
    @(negedge clk);
    p1_write = 0; p1_byteenable = 4'hF;
    p0_read = 1; p0_address = 16'h0100;
    #1;
    chk1("t3_p0_wait", p0_waitrequest, 1'b0);
    chk1("t3_wr_no_rdv", p1_readdatavalid, 1'b0);
    @(negedge clk);
    p0_read = 0;
    #1;
    chk1("t3_p0_rdv", p0_readdatavalid, 1'b1);
    chk32("t3_p0_data", p0_readdata, 32'h1000_BEEF);

    // 4: alternating single requests p0, p1, p0
    @(negedge clk);
    p0_read = 1; p0_address = 16'h0040;
    #1;
    chk1("t4a_p0_wait", p0_waitrequest, 1'b0);
    @(negedge clk);
    p0_read = 0; p1_read = 1; p1_address = 16'h0041;
    #1;
    chk1("t4b_p1_wait", p1_waitrequest, 1'b0);
    chk1("t4b_p0_rdv", p0_readdatavalid, 1'b1);
    chk32("t4b_p0_data", p0_readdata, 32'h1000_0040);
    chk1("t4b_p1_rdv", p1_readdatavalid, 1'b0);
    @(negedge clk);
    p1_read = 0; p0_read = 1; p0_address = 16'h0042;
    #1;
    chk1("t4c_p0_wait", p0_waitrequest, 1'b0);
    chk1("t4c_p1_rdv", p1_readdatavalid, 1'b1);
    chk32("t4c_p1_data", p1_readdata, 32'h1000_0041);
    chk1("t4c_p0_rdv", p0_readdatavalid, 1'b0);
    @(negedge clk);
    p0_read = 0;
    #1;
    chk1("t4d_p0_rdv", p0_readdatavalid, 1'b1);
    chk32("t4d_p0_data", p0_readdata, 32'h1000_0042);
    chk1("t4d_p1_rdv", p1_readdatavalid, 1'b0);
    @(negedge clk); #1;
    chk1("t4e_p0_rdv", p0_readdatavalid, 1'b0);
    chk1("t4e_p1_rdv", p1_readdatavalid, 1'b0);

    // 5: reset right after a p1 read issue
    @(negedge clk);
    p1_read = 1; p1_address = 16'h0050;
    #1;
    chk1("t5_p1_wait", p1_waitrequest, 1'b0);
    @(negedge clk);
    reset = 1; p0_read = 1; p0_address = 16'h0051;
    #1;
    chk1("t5_p1_rdv_drop", p1_readdatavalid, 1'b0);
    chk1("t5_p0_wait_rst", p0_waitrequest, 1'b1);
    chk1("t5_p1_wait_rst", p1_waitrequest, 1'b1);
    chk1("t5_cs_rst", mem_chipselect, 1'b0);
    @(negedge clk); #1;
    chk1("t5_p1_rdv_rst2", p1_readdatavalid, 1'b0);
    chk1("t5_p0_wait_rst2", p0_waitrequest, 1'b1);
    @(negedge clk);
    reset = 0;
    #1;
    chk1("t5_p0_prio", p0_waitrequest, 1'b0);
    chk1("t5_p1_blocked", p1_waitrequest, 1'b1);
    @(negedge clk);
    p0_read = 0; p1_read = 0;
    #1;
    chk1("t5_p0_rdv", p0_readdatavalid, 1'b1);
    chk32("t5_p0_data", p0_readdata, 32'h1000_0051);

    // 6: p1 streams alone well past MAX_BURST with no stalls
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      p1_read = 1; p1_address = 16'h0060 + 16'(i);
      #1;
      chk1($sformatf("t6_p1_wait_%0d", i), p1_waitrequest, 1'b0);
      if (i > 0) begin
        chk1($sformatf("t6_p1_rdv_%0d", i), p1_readdatavalid, 1'b1);
        chk32($sformatf("t6_p1_data_%0d", i), p1_readdata, 32'h1000_0060 + 32'(i - 1));
      end
    end
    @(negedge clk);
    p1_read = 0;
    #1;
    chk1("t6_p1_rdv_last", p1_readdatavalid, 1'b1);
    chk32("t6_p1_data_last", p1_readdata, 32'h1000_0073);
    chk1("t6_p0_rdv", p0_readdatavalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
